// File: rtl/cpu_if_pkg.sv
// Shared definitions for the CPU instruction-load interface.
// Holds the line geometry, the NOP pad value, the packer state type and the
// 16-bit byte swap helper. The CPU-side decoder uses the same helper.
package cpu_if_pkg;

  localparam int INW             = 512;
  localparam int INSTRW          = 16;
  localparam int NUMINSTRUCTIONS = INW / INSTRW;

  localparam logic [INSTRW-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  // Instructions are stored big-endian in the program file, so the first
  // byte on the stream ends up as the most significant byte.
  function automatic logic [INSTRW-1:0] bswap16(input logic [INSTRW-1:0] x);
    return {x[7:0], x[15:8]};
  endfunction

endpackage

// File: rtl/instr_byte_swap.sv
// Splits one DMA word into two instructions in program order.
// Ports: word (DMA word, byte 0 = word[7:0]) -> instr_a (first), instr_b (second).
// Purely combinational.
module instr_byte_swap
  import cpu_if_pkg::*;
#(
  parameter int WORDW = 2 * INSTRW
) (
  input  logic [WORDW-1:0]  word,
  output logic [INSTRW-1:0] instr_a,
  output logic [INSTRW-1:0] instr_b
);

  // Bytes b0,b1 form the first instruction {b0,b1}; b2,b3 form the second.
  assign instr_a = bswap16(word[INSTRW-1:0]);
  assign instr_b = bswap16(word[2*INSTRW-1:INSTRW]);

endmodule

// File: rtl/instr_line_packer.sv
// Packs a 32-bit DMA instruction stream into 512-bit lines for the CPU.
// Ports: clk/rst (sync, active high); rd_valid/rd_data/rd_last/dma_ready on
// the DMA side; common_data_bus_in/instr_write_en/cpu_ready/line_addr/
// load_done on the CPU side. All outputs come from registers or state decode.
module instr_line_packer
  import cpu_if_pkg::*;
#(
  parameter int WORDW = 32,
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid,
  input  logic [WORDW-1:0] rd_data,
  input  logic             rd_last,
  output logic             dma_ready,
  output logic [INW-1:0]   common_data_bus_in,
  output logic             instr_write_en,
  input  logic             cpu_ready,
  output logic [ADDRW-1:0] line_addr,
  output logic             load_done
);

  localparam int WORDS_PER_LINE = INW / WORDW;
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_LINE - 1);
  localparam logic [INW-1:0] NOP_LINE = {NUMINSTRUCTIONS{NOP_INSTR}};

  packer_state_t     state_q;
  logic [3:0]        word_cnt;
  logic [INW-1:0]    line_q;
  logic              last_flag;
  logic [ADDRW-1:0]  line_addr_q;
  logic              load_done_q;

  logic [INSTRW-1:0] instr_a;
  logic [INSTRW-1:0] instr_b;

  instr_byte_swap #(
    .WORDW (WORDW)
  ) u_swap (
    .word    (rd_data),
    .instr_a (instr_a),
    .instr_b (instr_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      word_cnt    <= 4'd0;
      line_q      <= NOP_LINE;
      last_flag   <= 1'b0;
      line_addr_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (rd_valid) begin
            // Word w lands in slots 2w (low half) and 2w+1 (high half).
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
              if (word_cnt == w[3:0]) begin
                line_q[w*WORDW +: WORDW] <= {instr_b, instr_a};
              end
            end
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == LAST_WORD || rd_last) begin
              state_q   <= HOLD;
              last_flag <= rd_last;
            end
          end
        end
        HOLD: begin
          if (cpu_ready) begin
            state_q  <= FILL;
            word_cnt <= 4'd0;
            // Preset so a short final line is padded with NOPs.
            line_q   <= NOP_LINE;
            if (last_flag) begin
              line_addr_q <= '0;
              load_done_q <= 1'b1;
            end else begin
              line_addr_q <= line_addr_q + ADDRW'(1);
            end
            last_flag <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign dma_ready          = (state_q == FILL);
  assign instr_write_en     = (state_q == HOLD);
  assign common_data_bus_in = line_q;
  assign line_addr          = line_addr_q;
  assign load_done          = load_done_q;

endmodule

// File: tb/tb_instr_line_packer.sv
module tb_instr_line_packer;

  logic         clk;
  logic         rst;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         dma_ready;
  logic [511:0] common_data_bus_in;
  logic         instr_write_en;
  logic         cpu_ready;
  logic [31:0]  line_addr;
  logic         load_done;

  instr_line_packer dut (
    .clk                (clk),
    .rst                (rst),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .rd_last            (rd_last),
    .dma_ready          (dma_ready),
    .common_data_bus_in (common_data_bus_in),
    .instr_write_en     (instr_write_en),
    .cpu_ready          (cpu_ready),
    .line_addr          (line_addr),
    .load_done          (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] line;
    logic [31:0]  addr;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  int           compared   = 0;
  int           mismatched = 0;
  logic [31:0]  exp_addr   = 0;
  logic [31:0]  wbuf [16];
  logic [511:0] last_bus;
  logic         done_pending = 1'b0;
  int           done_pulses  = 0;
  int           writes_seen  = 0;

  // Scoreboard monitor: a line is committed on any cycle with
  // instr_write_en and cpu_ready both high; load_done must follow one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (done_pending) begin
      compared++;
      if (load_done !== 1'b1) begin
        mismatched++;
        $display("FAIL load_done_pulse: got %b want 1", load_done);
      end
      done_pulses++;
      done_pending = 1'b0;
    end else if (load_done === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL load_done_spurious: got 1 want 0");
    end
    if (!rst && instr_write_en === 1'b1 && cpu_ready === 1'b1) begin
      writes_seen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got write at addr %0d want none", line_addr);
      end else begin
        e = sb.pop_front();
        compared++;
        if (common_data_bus_in !== e.line) begin
          mismatched++;
          $display("FAIL line_data addr %0d: got %h want %h", e.addr, common_data_bus_in, e.line);
        end
        compared++;
        if (line_addr !== e.addr) begin
          mismatched++;
          $display("FAIL line_addr: got %0d want %0d", line_addr, e.addr);
        end
        last_bus = common_data_bus_in;
        if (e.last) done_pending = 1'b1;
      end
    end
  end

  // Expected line built straight from the stream bytes: b0,b1 -> slot 2w, b2,b3 -> slot 2w+1.
  task automatic push_expected(input int n, input logic last);
    exp_t e;
    logic [31:0] d;
    e.line = '0;
    for (int i = 0; i < n; i++) begin
      d = wbuf[i];
      e.line[32*i +: 16]      = {d[7:0], d[15:8]};
      e.line[32*i + 16 +: 16] = {d[23:16], d[31:24]};
    end
    e.addr = exp_addr;
    e.last = last;
    sb.push_back(e);
    exp_addr = last ? 32'd0 : exp_addr + 32'd1;
  endtask

  task automatic drive_words(input int n, input logic last, input logic sparse);
    int bound;
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = wbuf[i];
      rd_last  = last && (i == n - 1);
      bound = 0;
      while (dma_ready !== 1'b1 && bound < 2000) begin
        @(posedge clk); #1;
        bound++;
      end
      if (bound >= 2000) begin
        compared++;
        mismatched++;
        $display("FAIL dma_ready_timeout: got 0 want 1");
      end
      @(posedge clk); #1;
      rd_valid = 1'b0;
      rd_last  = 1'b0;
      if (sparse) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_line(input int n, input logic last, input logic sparse);
    push_expected(n, last);
    drive_words(n, last, sparse);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  task automatic fill_counting();
    for (int i = 0; i < 16; i++)
      wbuf[i] = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
  endtask

  task automatic wait_drain();
    int bound = 0;
    while ((sb.size() != 0 || done_pending) && bound < 2000) begin
      @(posedge clk); #1;
      bound++;
    end
    if (bound >= 2000) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending lines want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input logic [31:0] want_addr);
    compared++;
    if (dma_ready !== 1'b1 || instr_write_en !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_handshake: got rdy=%b wen=%b want rdy=1 wen=0", dma_ready, instr_write_en);
    end
    compared++;
    if (line_addr !== want_addr) begin
      mismatched++;
      $display("FAIL idle_line_addr: got %0d want %0d", line_addr, want_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_last = 1'b0; cpu_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_addr = 0;
    check_idle(32'd0);
    compared++;
    if (load_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_load_done: got %b want 0", load_done);
    end
    compared++;
    if (common_data_bus_in !== {512{1'b0}}) begin
      mismatched++;
      $display("FAIL reset_bus_nop: got %h want all zero", common_data_bus_in);
    end
  endtask

  task automatic test_full_line();
    fill_counting();
    send_line(16, 1'b0, 1'b0);
    wait_drain();
    compared++;
    if (last_bus[15:0] !== 16'h0102 || last_bus[31:16] !== 16'h0304) begin
      mismatched++;
      $display("FAIL full_slot01: got %h %h want 0102 0304", last_bus[15:0], last_bus[31:16]);
    end
    check_idle(32'd1);
  endtask

  task automatic test_short_line();
    int p0 = done_pulses;
    fill_random(3);
    send_line(3, 1'b1, 1'b0);
    wait_drain();
    compared++;
    if (last_bus[511:96] !== {416{1'b0}}) begin
      mismatched++;
      $display("FAIL short_pad: got %h want all zero", last_bus[511:96]);
    end
    compared++;
    if (done_pulses - p0 != 1) begin
      mismatched++;
      $display("FAIL short_done_count: got %0d want 1", done_pulses - p0);
    end
    check_idle(32'd0);
  endtask

  task automatic test_sparse();
    fill_counting();
    send_line(16, 1'b0, 1'b1);
    fill_random(16);
    send_line(16, 1'b0, 1'b1);
    wait_drain();
    check_idle(32'd2);
  endtask

  task automatic test_backpressure();
    logic [511:0] held;
    int bound = 0;
    cpu_ready = 1'b0;
    fill_random(16);
    send_line(16, 1'b0, 1'b0);
    while (instr_write_en !== 1'b1 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    @(negedge clk);
    held = common_data_bus_in;
    // Junk offered while holding must not be taken.
    rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (common_data_bus_in !== held || instr_write_en !== 1'b1 || dma_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold cycle %0d: got wen=%b rdy=%b bus_same=%b want 1 0 1",
                 i, instr_write_en, dma_ready, common_data_bus_in === held);
      end
    end
    rd_valid  = 1'b0;
    cpu_ready = 1'b1;
    wait_drain();
    check_idle(32'd3);
  endtask

  task automatic test_reset_mid_fill();
    int w0 = writes_seen;
    fill_random(8);
    drive_words(8, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (writes_seen != w0) begin
      mismatched++;
      $display("FAIL rst_no_write: got %0d writes want 0", writes_seen - w0);
    end
    compared++;
    if (common_data_bus_in !== {512{1'b0}}) begin
      mismatched++;
      $display("FAIL rst_nop_preset: got %h want all zero", common_data_bus_in);
    end
    check_idle(32'd0);
    fill_random(16);
    send_line(16, 1'b0, 1'b0);
    wait_drain();
    check_idle(32'd1);
  endtask

  task automatic test_last_on_word15();
    int p0 = done_pulses;
    int w0 = writes_seen;
    fill_random(16);
    send_line(16, 1'b0, 1'b0);
    fill_random(16);
    send_line(16, 1'b1, 1'b0);
    wait_drain();
    compared++;
    if (writes_seen - w0 != 2 || done_pulses - p0 != 1) begin
      mismatched++;
      $display("FAIL last15_counts: got writes=%0d done=%0d want 2 1", writes_seen - w0, done_pulses - p0);
    end
    check_idle(32'd0);
  endtask

  task automatic test_back_to_back();
    fill_random(16);
    send_line(16, 1'b0, 1'b0);
    fill_random(5);
    send_line(5, 1'b1, 1'b0);
    wait_drain();
    check_idle(32'd0);
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short_line();
    test_sparse();
    test_backpressure();
    test_reset_mid_fill();
    test_last_on_word15();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
